// File: rtl/cam_pkg.sv
// Shared types, limits and helpers for the parametrised CAM.
// Imported by the priority encoder and the CAM top.
package cam_pkg;

  localparam int unsigned MaxWidth = 64;
  localparam int unsigned MaxDepth = 256;
  localparam int unsigned MaxIdxW  = 8;

  // Index width for a given depth; never below one bit.
  function automatic int unsigned cam_idx_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Sized for the largest supported depth; narrower CAMs use the low bits of index.
  typedef struct packed {
    logic               valid;
    logic               multi;
    logic [MaxIdxW-1:0] index;
  } cam_search_res_t;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder with any-hit and multi-hit flags.
// Index is 0 when no request bit is set.
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int unsigned N = 32,
  localparam int unsigned IdxW = cam_idx_w(N)
) (
  input  logic [N-1:0]    req_i,
  output logic [IdxW-1:0] index_o,
  output logic            any_o,
  output logic            multi_o
);

  always_comb begin
    index_o = '0;
    // Scan downward so the lowest set bit is the last assignment.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        index_o = IdxW'(i);
      end
    end
  end

  assign any_o   = |req_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(req_i & (req_i - N'(1)));

endmodule

// File: rtl/param_cam.sv
// Parametrised CAM: per-entry valid bits, ternary search with a two-stage
// pipeline (hit vector, then priority encode) and free-slot tracking.
module param_cam
  import cam_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned IDX_W = cam_idx_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             read_enable_i,
  input  logic [IDX_W-1:0] read_index_i,
  input  logic             write_enable_i,
  input  logic [IDX_W-1:0] write_index_i,
  input  logic [WIDTH-1:0] write_data_i,
  input  logic             inval_enable_i,
  input  logic [IDX_W-1:0] inval_index_i,
  input  logic             search_enable_i,
  input  logic [WIDTH-1:0] search_data_i,
  input  logic [WIDTH-1:0] search_mask_i,
  output logic             read_valid_o,
  output logic [WIDTH-1:0] read_value_o,
  output logic             search_valid_o,
  output logic [IDX_W-1:0] search_index_o,
  output logic             search_multi_o,
  output logic             search_done_o,
  output logic             full_o,
  output logic [IDX_W-1:0] free_index_o
);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][WIDTH-1:0] entry_data;
  logic [DEPTH-1:0]            hit;

  logic             read_valid_q, read_valid_d;
  logic [WIDTH-1:0] read_value_q, read_value_d;

  logic [DEPTH-1:0] hit_q, hit_d;
  logic             s1_done_q;
  cam_search_res_t  res_q, res_d;
  logic             s2_done_q;

  logic [IDX_W-1:0] enc_index;
  logic             enc_any;
  logic             enc_multi;
  logic [IDX_W-1:0] free_index;
  logic             free_any;
  logic             free_multi;

  // Storage and compare, one slice per entry. Data is deliberately not reset.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
      if (write_enable_i && (write_index_i == IDX_W'(i))) begin
        data_q <= write_data_i;
      end
    end

    assign entry_data[i] = data_q;
    assign hit[i] = valid_q[i] &&
                    (((data_q ^ search_data_i) & search_mask_i) == '0);
  end

  // Write is applied after invalidate so it wins on an index collision.
  always_comb begin
    valid_d = valid_q;
    if (inval_enable_i) begin
      valid_d[inval_index_i] = 1'b0;
    end
    if (write_enable_i) begin
      valid_d[write_index_i] = 1'b1;
    end
  end

  always_comb begin
    read_valid_d = 1'b0;
    read_value_d = '0;
    if (read_enable_i && valid_q[read_index_i]) begin
      read_valid_d = 1'b1;
      read_value_d = entry_data[read_index_i];
    end
  end

  // An idle stage carries an all-zero hit vector so the encoder outputs idle at 0.
  assign hit_d = search_enable_i ? hit : '0;

  cam_prio_enc #(
    .N (DEPTH)
  ) u_search_enc (
    .req_i   (hit_q),
    .index_o (enc_index),
    .any_o   (enc_any),
    .multi_o (enc_multi)
  );

  always_comb begin
    res_d                   = '0;
    res_d.valid             = enc_any;
    res_d.multi             = enc_multi;
    res_d.index[IDX_W-1:0]  = enc_index;
  end

  cam_prio_enc #(
    .N (DEPTH)
  ) u_free_enc (
    .req_i   (~valid_q),
    .index_o (free_index),
    .any_o   (free_any),
    .multi_o (free_multi)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q      <= '0;
      read_valid_q <= 1'b0;
      read_value_q <= '0;
      hit_q        <= '0;
      s1_done_q    <= 1'b0;
      res_q        <= '0;
      s2_done_q    <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      read_valid_q <= read_valid_d;
      read_value_q <= read_value_d;
      hit_q        <= hit_d;
      s1_done_q    <= search_enable_i;
      res_q        <= res_d;
      s2_done_q    <= s1_done_q;
    end
  end

  assign read_valid_o   = read_valid_q;
  assign read_value_o   = read_value_q;
  assign search_valid_o = res_q.valid;
  assign search_index_o = res_q.index[IDX_W-1:0];
  assign search_multi_o = res_q.multi;
  assign search_done_o  = s2_done_q;
  assign full_o         = ~free_any;
  assign free_index_o   = free_index;

  logic unused_bits;
  assign unused_bits = ^{free_multi, res_q.index};

endmodule

// File: tb/tb_param_cam.sv
// Directed self-checking bench for param_cam at the default 32x32 size.
module tb_param_cam;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned IDX_W = 5;

  logic             clk;
  logic             rst_n;
  logic             read_enable;
  logic [IDX_W-1:0] read_index;
  logic             write_enable;
  logic [IDX_W-1:0] write_index;
  logic [WIDTH-1:0] write_data;
  logic             inval_enable;
  logic [IDX_W-1:0] inval_index;
  logic             search_enable;
  logic [WIDTH-1:0] search_data;
  logic [WIDTH-1:0] search_mask;
  logic             read_valid;
  logic [WIDTH-1:0] read_value;
  logic             search_valid;
  logic [IDX_W-1:0] search_index;
  logic             search_multi;
  logic             search_done;
  logic             full;
  logic [IDX_W-1:0] free_index;

  int n_vec  = 0;
  int n_miss = 0;

  param_cam #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_n),
    .read_enable_i   (read_enable),
    .read_index_i    (read_index),
    .write_enable_i  (write_enable),
    .write_index_i   (write_index),
    .write_data_i    (write_data),
    .inval_enable_i  (inval_enable),
    .inval_index_i   (inval_index),
    .search_enable_i (search_enable),
    .search_data_i   (search_data),
    .search_mask_i   (search_mask),
    .read_valid_o    (read_valid),
    .read_value_o    (read_value),
    .search_valid_o  (search_valid),
    .search_index_o  (search_index),
    .search_multi_o  (search_multi),
    .search_done_o   (search_done),
    .full_o          (full),
    .free_index_o    (free_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_enable   = 1'b0;
    write_enable  = 1'b0;
    inval_enable  = 1'b0;
    search_enable = 1'b0;
  endtask

  task automatic chk_search(input string tag, input logic done, input logic vld,
                            input logic [IDX_W-1:0] idx, input logic multi);
    chk({tag, ".done"},  64'(search_done),  64'(done));
    chk({tag, ".valid"}, 64'(search_valid), 64'(vld));
    chk({tag, ".index"}, 64'(search_index), 64'(idx));
    chk({tag, ".multi"}, 64'(search_multi), 64'(multi));
  endtask

  initial begin
    rst_n       = 1'b0;
    read_index  = '0;
    write_index = '0;
    write_data  = '0;
    inval_index = '0;
    search_data = '0;
    search_mask = '0;
    idle();
    step();
    step();

    // Reset state
    chk("rst.read_valid", 64'(read_valid), 64'd0);
    chk("rst.read_value", 64'(read_value), 64'd0);
    chk_search("rst", 1'b0, 1'b0, '0, 1'b0);
    chk("rst.full", 64'(full), 64'd0);
    chk("rst.free", 64'(free_index), 64'd0);
    rst_n = 1'b1;
    step();

    // Write then read
    write_enable = 1'b1; write_index = 5'd5; write_data = 32'hDEADBEEF;
    step();
    idle();
    chk("wr5.free", 64'(free_index), 64'd0);
    read_enable = 1'b1; read_index = 5'd5;
    step();
    chk("rd5.valid", 64'(read_valid), 64'd1);
    chk("rd5.value", 64'(read_value), 64'hDEADBEEF);
    read_index = 5'd6;
    step();
    chk("rd6.valid", 64'(read_valid), 64'd0);
    chk("rd6.value", 64'(read_value), 64'd0);

    // Read and write same index: old contents returned
    write_enable = 1'b1; write_index = 5'd5; write_data = 32'h11;
    read_index = 5'd5;
    step();
    chk("rdw5.value", 64'(read_value), 64'hDEADBEEF);
    write_enable = 1'b0;
    step();
    chk("rd5new.value", 64'(read_value), 64'h11);
    idle();
    step();
    chk("rdidle.valid", 64'(read_valid), 64'd0);

    // Multi-hit search
    write_enable = 1'b1; write_index = 5'd3; write_data = 32'hA5;
    step();
    write_index = 5'd9;
    step();
    idle();
    search_enable = 1'b1; search_data = 32'hA5; search_mask = 32'hFFFFFFFF;
    step();
    idle();
    chk("a5.early_done", 64'(search_done), 64'd0);
    step();
    chk_search("a5", 1'b1, 1'b1, 5'd3, 1'b1);
    step();
    chk_search("a5.after", 1'b0, 1'b0, '0, 1'b0);

    // Ternary search, then full mask back-to-back
    write_enable = 1'b1; write_index = 5'd7; write_data = 32'h12345678;
    step();
    idle();
    search_enable = 1'b1; search_data = 32'h123456FF; search_mask = 32'hFFFFFF00;
    step();
    search_mask = 32'hFFFFFFFF;
    step();
    idle();
    chk_search("tern", 1'b1, 1'b1, 5'd7, 1'b0);
    step();
    chk_search("fullmask", 1'b1, 1'b0, '0, 1'b0);
    step();
    chk("fullmask.after", 64'(search_done), 64'd0);

    // Snapshot: search with a same-cycle write misses, the next one hits
    search_enable = 1'b1; search_data = 32'h55; search_mask = 32'hFFFFFFFF;
    write_enable = 1'b1; write_index = 5'd2; write_data = 32'h55;
    step();
    write_enable = 1'b0;
    step();
    idle();
    chk_search("snap.miss", 1'b1, 1'b0, '0, 1'b0);
    step();
    chk_search("snap.hit", 1'b1, 1'b1, 5'd2, 1'b0);

    // Zero mask hits every valid entry (2,3,5,7,9)
    search_enable = 1'b1; search_mask = '0;
    step();
    idle();
    step();
    chk_search("zmask", 1'b1, 1'b1, 5'd2, 1'b1);

    // Fill every entry
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      write_enable = 1'b1; write_index = IDX_W'(i); write_data = 32'h1000 + i;
      step();
    end
    chk("fill31.full", 64'(full), 64'd0);
    chk("fill31.free", 64'(free_index), 64'd31);
    write_index = 5'd31; write_data = 32'h101F;
    step();
    idle();
    chk("fill.full", 64'(full), 64'd1);
    chk("fill.free", 64'(free_index), 64'd0);

    inval_enable = 1'b1; inval_index = 5'd4;
    step();
    idle();
    chk("inv4.full", 64'(full), 64'd0);
    chk("inv4.free", 64'(free_index), 64'd4);

    // Invalid entry never hits even though its data matches
    search_enable = 1'b1; search_data = 32'h1004; search_mask = 32'hFFFFFFFF;
    step();
    idle();
    step();
    chk_search("inv4.search", 1'b1, 1'b0, '0, 1'b0);

    write_enable = 1'b1; write_index = 5'd4; write_data = 32'h44;
    inval_enable = 1'b1; inval_index = 5'd4;
    step();
    idle();
    chk("wrinv4.full", 64'(full), 64'd1);
    chk("wrinv4.free", 64'(free_index), 64'd0);

    write_enable = 1'b1; write_index = 5'd4; write_data = 32'h77;
    inval_enable = 1'b1; inval_index = 5'd10;
    step();
    idle();
    chk("wr4inv10.free", 64'(free_index), 64'd10);
    read_enable = 1'b1; read_index = 5'd4;
    step();
    idle();
    chk("rd4.valid", 64'(read_valid), 64'd1);
    chk("rd4.value", 64'(read_value), 64'h77);

    // Reset one cycle after a search is issued
    search_enable = 1'b1; search_mask = '0;
    step();
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst.done", 64'(search_done), 64'd0);
    chk("midrst.full", 64'(full), 64'd0);
    chk("midrst.free", 64'(free_index), 64'd0);
    step();
    chk_search("midrst.held", 1'b0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    read_enable = 1'b1; read_index = 5'd4;
    step();
    idle();
    chk("postrst.done", 64'(search_done), 64'd0);
    chk("postrst.read_valid", 64'(read_valid), 64'd0);
    chk("postrst.free", 64'(free_index), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
